// File: rtl/axi_ddr_id_remap_pkg.sv
// Shared constants for the DDR-side AXI ID remapper in front of the MIG.
package axi_ddr_id_remap_pkg;

    localparam int unsigned K_DDR_AXI_ID_WIDTH = 4;
    localparam int unsigned K_DDR_MAX_IDS      = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// One direction of the ID remap: maps wide upstream IDs onto a small set of
// entry indices and counts in-flight transactions per entry.
module axi_id_remap_table
    import axi_ddr_id_remap_pkg::*;
#(
    parameter int unsigned ID_W_IN  = 10,
    parameter int unsigned ID_W_OUT = 4,
    parameter int unsigned MAX_IDS  = 4,
    parameter int unsigned MAX_TXNS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_W_IN-1:0]  i_lookup_id,
    output logic                o_can_accept,
    output logic [ID_W_OUT-1:0] o_idx,
    input  logic                i_alloc,
    input  logic                i_retire,
    input  logic [ID_W_OUT-1:0] i_retire_idx,
    output logic [ID_W_IN-1:0]  o_in_id
);

    localparam int unsigned IdxW = idx_width(MAX_IDS);
    localparam int unsigned CntW = $clog2(MAX_TXNS + 1);
    typedef logic [CntW-1:0] cnt_t;

    logic [MAX_IDS-1:0] r_valid;
    logic [ID_W_IN-1:0] r_in_id [MAX_IDS];
    cnt_t               r_cnt   [MAX_IDS];

    logic [MAX_IDS-1:0] w_valid_nxt;
    logic [ID_W_IN-1:0] w_in_id_nxt [MAX_IDS];
    cnt_t               w_cnt_nxt   [MAX_IDS];
    logic [MAX_IDS-1:0] w_inc;
    logic [MAX_IDS-1:0] w_dec;

    logic            w_hit;
    logic            w_free;
    logic [IdxW-1:0] w_hit_idx;
    logic [IdxW-1:0] w_free_idx;
    logic [IdxW-1:0] w_sel_idx;
    logic [IdxW-1:0] w_ret_idx;
    logic            w_ret_in_range;
    logic            w_retire_ok;

    // Scan from the top so the lowest matching/free index is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_free     = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = MAX_IDS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_in_id[i] == i_lookup_id)) begin
                w_hit     = 1'b1;
                w_hit_idx = IdxW'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IdxW'(i);
            end
        end
    end

    assign w_sel_idx      = w_hit ? w_hit_idx : w_free_idx;
    assign o_can_accept   = w_hit ? (r_cnt[w_hit_idx] < cnt_t'(MAX_TXNS)) : w_free;
    assign o_idx          = ID_W_OUT'(w_sel_idx);
    assign w_ret_idx      = i_retire_idx[IdxW-1:0];
    assign w_ret_in_range = 32'(i_retire_idx) < MAX_IDS;
    assign w_retire_ok    = w_ret_in_range && r_valid[w_ret_idx] && (r_cnt[w_ret_idx] != '0);
    assign o_in_id        = w_ret_in_range ? r_in_id[w_ret_idx] : '0;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < MAX_IDS; i++) begin
            w_inc[i] = i_alloc && (w_sel_idx == IdxW'(i));
            w_dec[i] = i_retire && w_retire_ok && (w_ret_idx == IdxW'(i));
        end
    end

    // A same-cycle alloc and retire on one entry cancel out.
    always_comb begin
        w_valid_nxt = r_valid;
        w_in_id_nxt = r_in_id;
        w_cnt_nxt   = r_cnt;
        for (int i = 0; i < MAX_IDS; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
                if (w_hit) begin
                    w_cnt_nxt[i] = r_cnt[i] + cnt_t'(1);
                end else begin
                    w_valid_nxt[i] = 1'b1;
                    w_in_id_nxt[i] = i_lookup_id;
                    w_cnt_nxt[i]   = cnt_t'(1);
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - cnt_t'(1);
                if (r_cnt[i] == cnt_t'(1)) begin
                    w_valid_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < MAX_IDS; i++) begin
                r_in_id[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_in_id <= w_in_id_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && i_retire) begin
            assert (w_retire_ok)
            else $error("response retires an invalid or empty remap entry");
        end
    end
`endif

endmodule

// File: rtl/axi_ddr_id_remap.sv
// Compresses crossbar AXI IDs to the narrow MIG ID space and restores them on R/B.
module axi_ddr_id_remap
    import axi_ddr_id_remap_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 64,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_USER_WIDTH   = 1,
    parameter int unsigned AXI_ID_WIDTH_IN  = 10,
    parameter int unsigned AXI_ID_WIDTH_OUT = K_DDR_AXI_ID_WIDTH,
    parameter int unsigned MAX_IDS          = K_DDR_MAX_IDS,
    parameter int unsigned MAX_TXNS_PER_ID  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // slave AW
    input  logic                        i_s_aw_valid,
    output logic                        o_s_aw_ready,
    input  logic [AXI_ID_WIDTH_IN-1:0]  i_s_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_s_aw_addr,
    input  logic [7:0]                  i_s_aw_len,
    input  logic [2:0]                  i_s_aw_size,
    input  logic [1:0]                  i_s_aw_burst,
    input  logic                        i_s_aw_lock,
    input  logic [3:0]                  i_s_aw_cache,
    input  logic [2:0]                  i_s_aw_prot,
    input  logic [3:0]                  i_s_aw_qos,
    input  logic [AXI_USER_WIDTH-1:0]   i_s_aw_user,
    // slave W
    input  logic                        i_s_w_valid,
    output logic                        o_s_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_s_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] i_s_w_strb,
    input  logic                        i_s_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   i_s_w_user,
    // slave B
    output logic                        o_s_b_valid,
    input  logic                        i_s_b_ready,
    output logic [AXI_ID_WIDTH_IN-1:0]  o_s_b_id,
    output logic [1:0]                  o_s_b_resp,
    output logic [AXI_USER_WIDTH-1:0]   o_s_b_user,
    // slave AR
    input  logic                        i_s_ar_valid,
    output logic                        o_s_ar_ready,
    input  logic [AXI_ID_WIDTH_IN-1:0]  i_s_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_s_ar_addr,
    input  logic [7:0]                  i_s_ar_len,
    input  logic [2:0]                  i_s_ar_size,
    input  logic [1:0]                  i_s_ar_burst,
    input  logic                        i_s_ar_lock,
    input  logic [3:0]                  i_s_ar_cache,
    input  logic [2:0]                  i_s_ar_prot,
    input  logic [3:0]                  i_s_ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   i_s_ar_user,
    // slave R
    output logic                        o_s_r_valid,
    input  logic                        i_s_r_ready,
    output logic [AXI_ID_WIDTH_IN-1:0]  o_s_r_id,
    output logic [AXI_DATA_WIDTH-1:0]   o_s_r_data,
    output logic [1:0]                  o_s_r_resp,
    output logic                        o_s_r_last,
    output logic [AXI_USER_WIDTH-1:0]   o_s_r_user,
    // master AW
    output logic                        o_m_aw_valid,
    input  logic                        i_m_aw_ready,
    output logic [AXI_ID_WIDTH_OUT-1:0] o_m_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   o_m_aw_addr,
    output logic [7:0]                  o_m_aw_len,
    output logic [2:0]                  o_m_aw_size,
    output logic [1:0]                  o_m_aw_burst,
    output logic                        o_m_aw_lock,
    output logic [3:0]                  o_m_aw_cache,
    output logic [2:0]                  o_m_aw_prot,
    output logic [3:0]                  o_m_aw_qos,
    output logic [AXI_USER_WIDTH-1:0]   o_m_aw_user,
    // master W
    output logic                        o_m_w_valid,
    input  logic                        i_m_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   o_m_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] o_m_w_strb,
    output logic                        o_m_w_last,
    output logic [AXI_USER_WIDTH-1:0]   o_m_w_user,
    // master B
    input  logic                        i_m_b_valid,
    output logic                        o_m_b_ready,
    input  logic [AXI_ID_WIDTH_OUT-1:0] i_m_b_id,
    input  logic [1:0]                  i_m_b_resp,
    input  logic [AXI_USER_WIDTH-1:0]   i_m_b_user,
    // master AR
    output logic                        o_m_ar_valid,
    input  logic                        i_m_ar_ready,
    output logic [AXI_ID_WIDTH_OUT-1:0] o_m_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   o_m_ar_addr,
    output logic [7:0]                  o_m_ar_len,
    output logic [2:0]                  o_m_ar_size,
    output logic [1:0]                  o_m_ar_burst,
    output logic                        o_m_ar_lock,
    output logic [3:0]                  o_m_ar_cache,
    output logic [2:0]                  o_m_ar_prot,
    output logic [3:0]                  o_m_ar_qos,
    output logic [AXI_USER_WIDTH-1:0]   o_m_ar_user,
    // master R
    input  logic                        i_m_r_valid,
    output logic                        o_m_r_ready,
    input  logic [AXI_ID_WIDTH_OUT-1:0] i_m_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]   i_m_r_data,
    input  logic [1:0]                  i_m_r_resp,
    input  logic                        i_m_r_last,
    input  logic [AXI_USER_WIDTH-1:0]   i_m_r_user
);

    logic                       w_aw_can;
    logic                       w_ar_can;
    logic                       w_aw_hs;
    logic                       w_ar_hs;
    logic                       w_b_retire;
    logic                       w_r_retire;
    logic [AXI_ID_WIDTH_IN-1:0] w_b_in_id;
    logic [AXI_ID_WIDTH_IN-1:0] w_r_in_id;

    assign w_aw_hs    = i_s_aw_valid && i_m_aw_ready && w_aw_can;
    assign w_ar_hs    = i_s_ar_valid && i_m_ar_ready && w_ar_can;
    assign w_b_retire = i_m_b_valid && i_s_b_ready;
    assign w_r_retire = i_m_r_valid && i_s_r_ready && i_m_r_last;

    axi_id_remap_table #(
        .ID_W_IN  (AXI_ID_WIDTH_IN),
        .ID_W_OUT (AXI_ID_WIDTH_OUT),
        .MAX_IDS  (MAX_IDS),
        .MAX_TXNS (MAX_TXNS_PER_ID)
    ) u_wr_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_lookup_id  (i_s_aw_id),
        .o_can_accept (w_aw_can),
        .o_idx        (o_m_aw_id),
        .i_alloc      (w_aw_hs),
        .i_retire     (w_b_retire),
        .i_retire_idx (i_m_b_id),
        .o_in_id      (w_b_in_id)
    );

    axi_id_remap_table #(
        .ID_W_IN  (AXI_ID_WIDTH_IN),
        .ID_W_OUT (AXI_ID_WIDTH_OUT),
        .MAX_IDS  (MAX_IDS),
        .MAX_TXNS (MAX_TXNS_PER_ID)
    ) u_rd_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_lookup_id  (i_s_ar_id),
        .o_can_accept (w_ar_can),
        .o_idx        (o_m_ar_id),
        .i_alloc      (w_ar_hs),
        .i_retire     (w_r_retire),
        .i_retire_idx (i_m_r_id),
        .o_in_id      (w_r_in_id)
    );

    assign o_m_aw_valid = i_s_aw_valid && w_aw_can;
    assign o_s_aw_ready = i_m_aw_ready && w_aw_can;
    assign o_m_aw_addr  = i_s_aw_addr;
    assign o_m_aw_len   = i_s_aw_len;
    assign o_m_aw_size  = i_s_aw_size;
    assign o_m_aw_burst = i_s_aw_burst;
    assign o_m_aw_lock  = i_s_aw_lock;
    assign o_m_aw_cache = i_s_aw_cache;
    assign o_m_aw_prot  = i_s_aw_prot;
    assign o_m_aw_qos   = i_s_aw_qos;
    assign o_m_aw_user  = i_s_aw_user;

    assign o_m_w_valid  = i_s_w_valid;
    assign o_s_w_ready  = i_m_w_ready;
    assign o_m_w_data   = i_s_w_data;
    assign o_m_w_strb   = i_s_w_strb;
    assign o_m_w_last   = i_s_w_last;
    assign o_m_w_user   = i_s_w_user;

    assign o_s_b_valid  = i_m_b_valid;
    assign o_m_b_ready  = i_s_b_ready;
    assign o_s_b_id     = w_b_in_id;
    assign o_s_b_resp   = i_m_b_resp;
    assign o_s_b_user   = i_m_b_user;

    assign o_m_ar_valid = i_s_ar_valid && w_ar_can;
    assign o_s_ar_ready = i_m_ar_ready && w_ar_can;
    assign o_m_ar_addr  = i_s_ar_addr;
    assign o_m_ar_len   = i_s_ar_len;
    assign o_m_ar_size  = i_s_ar_size;
    assign o_m_ar_burst = i_s_ar_burst;
    assign o_m_ar_lock  = i_s_ar_lock;
    assign o_m_ar_cache = i_s_ar_cache;
    assign o_m_ar_prot  = i_s_ar_prot;
    assign o_m_ar_qos   = i_s_ar_qos;
    assign o_m_ar_user  = i_s_ar_user;

    assign o_s_r_valid  = i_m_r_valid;
    assign o_m_r_ready  = i_s_r_ready;
    assign o_s_r_id     = w_r_in_id;
    assign o_s_r_data   = i_m_r_data;
    assign o_s_r_resp   = i_m_r_resp;
    assign o_s_r_last   = i_m_r_last;
    assign o_s_r_user   = i_m_r_user;

endmodule
